// File: rtl/bcd_converter.sv
// bcd_converter: sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// Accepts a WIDTH-bit value on start while ready, processes one bit per clock,
// and publishes packed BCD digits (digit 0 in bits [3:0]) with a one-cycle done pulse.
module bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    bin_reg;
    logic [4*DIGITS-1:0] work;
    logic [CW-1:0]       count;

    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] shifted;

    // Add-3 correction on every working digit >= 5, then shift in the next binary MSB
    always_comb begin
        adjusted = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[4*DIGITS-2:0], bin_reg[WIDTH-1]};
    end

    // Control FSM with registered ready/done/bcd outputs
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            bcd     <= '0;
            bin_reg <= '0;
            work    <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg <= bin;
                        work    <= '0;
                        count   <= '0;
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work    <= shifted;
                    bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        bcd   <= shifted;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: directed and randomized checks of bcd_converter against an
// arithmetic (divide/modulo) decimal reference model.
module tb_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clock;
    logic                n_rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                ready;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    int unsigned checks;
    int unsigned passes;
    logic [4*DIGITS-1:0] last_bcd;

    bcd_converter #(
        .WIDTH (WIDTH),
        .DIGITS(DIGITS)
    ) dut (
        .clock(clock),
        .n_rst(n_rst),
        .start(start),
        .bin  (bin),
        .ready(ready),
        .done (done),
        .bcd  (bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decimal digits by repeated division, packed 4 bits per digit
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One full conversion; optionally pokes start (with a different bin) mid-conversion
    task automatic run_conv(input logic [WIDTH-1:0] v, input bit poke_busy);
        logic [4*DIGITS-1:0] exp;
        exp   = to_bcd(int'(v));
        start = 1'b1;
        bin   = v;
        @(posedge clock); #1;
        start = 1'b0;
        bin   = WIDTH'($urandom);
        chk("accept_ready", 32'(ready), 32'd0);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_bcd_hold", 32'(bcd), 32'(last_bcd));
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clock); #1;
            chk("busy_ready", 32'(ready), 32'd0);
            chk("busy_done", 32'(done), 32'd0);
            chk("busy_bcd_hold", 32'(bcd), 32'(last_bcd));
            bin   = WIDTH'($urandom);
            start = (poke_busy && i == 4) ? 1'b1 : 1'b0;
            if (poke_busy && i == 4) bin = 16'd9;
        end
        @(posedge clock); #1;
        start = 1'b0;
        chk("final_ready", 32'(ready), 32'd1);
        chk("final_done", 32'(done), 32'd1);
        chk("final_bcd", 32'(bcd), 32'(exp));
        last_bcd = exp;
        @(posedge clock); #1;
        chk("post_done", 32'(done), 32'd0);
        chk("post_ready", 32'(ready), 32'd1);
        chk("post_bcd", 32'(bcd), 32'(exp));
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        checks   = 0;
        passes   = 0;
        last_bcd = '0;
        n_rst    = 1'b0;
        start    = 1'b0;
        bin      = '0;

        // Reset state
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_bcd", 32'(bcd), 32'd0);
        end

        // Directed values, including the maximum input
        run_conv(16'd0, 1'b0);
        run_conv(16'd65025, 1'b0);
        run_conv(16'd65535, 1'b0);
        run_conv(16'd1234, 1'b0);

        // Start while busy is ignored; no second done pulse afterwards
        run_conv(16'd100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("nodup_done", 32'(done), 32'd0);
            chk("nodup_ready", 32'(ready), 32'd1);
            chk("nodup_bcd", 32'(bcd), 32'h00100);
        end

        // Back-to-back with start held high
        start = 1'b1;
        bin   = 16'd42;
        @(posedge clock); #1;
        chk("b2b_accept1", 32'(ready), 32'd0);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clock); #1;
            chk("b2b_busy1_done", 32'(done), 32'd0);
        end
        @(posedge clock); #1;
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_bcd1", 32'(bcd), 32'h00042);
        bin = 16'd9999;
        @(posedge clock); #1;
        chk("b2b_accept2_ready", 32'(ready), 32'd0);
        chk("b2b_accept2_done", 32'(done), 32'd0);
        start = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clock); #1;
            chk("b2b_busy2_done", 32'(done), 32'd0);
            chk("b2b_busy2_bcd", 32'(bcd), 32'h00042);
        end
        @(posedge clock); #1;
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_bcd2", 32'(bcd), 32'h09999);
        @(posedge clock); #1;
        chk("b2b_post_done", 32'(done), 32'd0);
        last_bcd = 20'h09999;

        // Randomized conversions against the arithmetic model
        for (int k = 0; k < 20; k++) begin
            v = WIDTH'($urandom_range(0, 65535));
            run_conv(v, 1'b0);
        end

        // Asynchronous reset mid-conversion
        start = 1'b1;
        bin   = 16'd500;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i < 7; i++) begin
            @(posedge clock);
        end
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'd0);
        @(negedge clock);
        n_rst    = 1'b1;
        last_bcd = '0;
        @(posedge clock); #1;
        chk("midrst_idle_bcd", 32'(bcd), 32'd0);
        run_conv(16'd7, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
